compensation_weight_generator: RTL and testbench
================================================

Name: compensation_weight_generator

Overview:
- Producer side of the compensation-weight load interface.
- After `start`, scans the SIZE x SIZE weight buffer one column at a time and finds outlier weights whose upper bits cannot be represented in the PE's 5-bit datapath.
- Emits each outlier's 3-bit compensation code with the valid / change-column / done protocol the compensation memory consumes.
- Sits between the weight buffer read port and the compensation memory load port.

Parameters:
- SIZE, 8, systolic array dimension (rows per column, number of columns).
- MAX_CMP, 3, compensation slots per column; fixed at 3 to match the memory layout.
- WADDR_WIDTH, $clog2(SIZE*SIZE), weight buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a full scan; ignored while busy=1.
- wmem_rd_en  out  1  weight buffer read enable.
- wmem_addr  out  WADDR_WIDTH  read address, column-major: col*SIZE+row.
- wmem_data  in  8  signed weight; valid the cycle after wmem_rd_en (1-cycle latency).
- Compensation_Weight  out  3  compensation code.
- Compensation_out_valid  out  1  code valid; one slot write per cycle.
- change_col  out  1  one-cycle pulse; advances the consumer to the next column group.
- load_mem_done  out  1  level; all columns delivered.
- busy  out  1  scan in progress.
- overflow  out  1  sticky; some column had more than MAX_CMP outliers.

Behaviour:
- Reset (rst==0 at posedge): the following clear to 0 on the next edge, from any state (including mid-scan), with no partial protocol completion:
  - state=IDLE;
  - all outputs 0: wmem_rd_en, wmem_addr, Compensation_Weight, Compensation_out_valid, change_col, load_mem_done, busy, overflow;
  - column counter, row counter, outlier count and entry buffer.
- Outlier rule: weight w is an outlier iff w[7:5] != {3{w[4]}}. Code = w[7:5].
- FSM states: IDLE, READ, EMIT, CHG, DONE.
- IDLE / DONE transitions:
  - start in IDLE or DONE -> READ, col=0, busy=1, load_mem_done=0, overflow=0.
  - start in any other state is ignored.
- READ:
  - Counter r runs 0..SIZE, one step per cycle (SIZE+1 cycles total).
  - For r<SIZE: wmem_rd_en=1, wmem_addr=col*SIZE+r.
  - For r>=1: evaluate wmem_data (row r-1). If it is an outlier and count<3, store its code in entry[count] and increment count. If it is an outlier and count==3, set overflow=1.
  - Leaving READ, entry order is ascending row.
- READ -> EMIT:
  - count==0: load entry[0]=3'd0, k=1.
  - Otherwise k=count.
- EMIT:
  - k cycles; Compensation_out_valid=1 and Compensation_Weight=entry[j] for j=0..k-1, consecutive cycles.
  - Then -> CHG.
- CHG:
  - Exactly one cycle: change_col=1, Compensation_out_valid=0.
  - change_col is never asserted in the same cycle as Compensation_out_valid.
  - Each column emits 1..3 entries followed by exactly one change_col.
  - CHG -> READ with col+1, or -> DONE if col==SIZE-1.
- DONE:
  - load_mem_done=1 from the cycle after the last CHG; held until the next start or reset.
  - busy=0.
  - Compensation_out_valid=0 and change_col=0.
- Per-column cycles = (SIZE+1) + k + 1.
- Registered outputs only; no combinational path from wmem_data to any output.
- Compensation_Weight holds its last value when not valid.

Test Plan:
- All-zero buffer, start -> per column exactly one valid with code 3'd0, then change_col; 8 valids, 8 change_cols. load_mem_done rises 88 cycles after start (8 columns x 11 cycles); overflow=0.
- Column 0 with row2=8'h40 and row5=8'hA0, all else 0 -> column 0 emits 3'b010 then 3'b101 on consecutive cycles, then change_col. Columns 1..7 emit single 3'd0 entries.
- Column 3 with rows 0..4=8'h40 -> column 3 emits three 3'b010 entries then change_col; overflow=1 and stays 1 through DONE. Row 8'hF5 (-11) alone is not an outlier.
- start pulsed mid-READ -> ignored, sequence unchanged. start in DONE -> load_mem_done=0 next cycle, scan restarts at address 0, overflow cleared.
- rst=0 during EMIT of column 4 -> next cycle all outputs 0, state IDLE. A subsequent start produces a complete 8-column sequence from column 0.
- Protocol checker over random buffers:
  - valid and change_col never both high;
  - 1..3 valids between change_cols;
  - exactly SIZE change_cols before load_mem_done;
  - each column's wmem_addr reads are sequential.

Source files
------------

// File: rtl/compensation_weight_generator.sv
// Compensation-weight producer: scans the weight buffer column by column, collects
// the codes of weights that do not fit the 5-bit PE datapath and streams them to the
// compensation memory with the valid / change_col / load_mem_done protocol.
module compensation_weight_generator #(
  parameter int SIZE        = 8,
  parameter int MAX_CMP     = 3,
  parameter int WADDR_WIDTH = $clog2(SIZE * SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   wmem_rd_en,
  output logic [WADDR_WIDTH-1:0] wmem_addr,
  input  logic [7:0]             wmem_data,
  output logic [2:0]             Compensation_Weight,
  output logic                   Compensation_out_valid,
  output logic                   change_col,
  output logic                   load_mem_done,
  output logic                   busy,
  output logic                   overflow
);

  localparam int CW = $clog2(SIZE);
  localparam int RW = $clog2(SIZE + 1);
  localparam int NW = $clog2(MAX_CMP + 1);

  typedef enum logic [2:0] {StIdle, StRead, StEmit, StChg, StDone} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               col_q, col_d;
  logic [RW-1:0]               row_q, row_d;
  logic [NW-1:0]               cnt_q, cnt_d;
  logic [NW-1:0]               num_q, num_d;
  logic [NW-1:0]               idx_q, idx_d;
  logic [MAX_CMP-1:0][2:0]     entry_q, entry_d;
  logic                        rd_en_q, rd_en_d;
  logic [WADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [2:0]                  cw_q, cw_d;
  logic                        valid_q, valid_d;
  logic                        chg_q, chg_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic                        ovf_q, ovf_d;
  logic                        outlier;

  // Upper three bits must be a sign extension of bit 4 to fit the datapath.
  assign outlier = (wmem_data[7:5] != {3{wmem_data[4]}});

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    cw_d    = cw_q;
    valid_d = 1'b0;
    chg_d   = 1'b0;
    done_d  = done_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRead;
          col_d   = '0;
          row_d   = '0;
          cnt_d   = '0;
          entry_d = '0;
          rd_en_d = 1'b1;
          addr_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StRead: begin
        // Data returned this cycle belongs to row row_q-1.
        if (row_q != '0 && outlier) begin
          if (cnt_q == NW'(MAX_CMP)) begin
            ovf_d = 1'b1;
          end else begin
            entry_d[cnt_q] = wmem_data[7:5];
            cnt_d          = cnt_q + 1'b1;
          end
        end
        if (row_q == RW'(SIZE)) begin
          state_d = StEmit;
          idx_d   = '0;
          // A column without outliers still sends one zero code.
          if (cnt_d == '0) begin
            entry_d[0] = 3'd0;
            num_d      = NW'(1);
          end else begin
            num_d = cnt_d;
          end
          valid_d = 1'b1;
          cw_d    = entry_d[0];
        end else begin
          row_d = row_q + 1'b1;
          if (row_d < RW'(SIZE)) begin
            rd_en_d = 1'b1;
            addr_d  = WADDR_WIDTH'(col_q) * WADDR_WIDTH'(SIZE) + WADDR_WIDTH'(row_d);
          end
        end
      end
      StEmit: begin
        if (idx_q + 1'b1 != num_q) begin
          idx_d   = idx_q + 1'b1;
          valid_d = 1'b1;
          cw_d    = entry_q[idx_d];
        end else begin
          state_d = StChg;
          chg_d   = 1'b1;
        end
      end
      StChg: begin
        if (col_q == CW'(SIZE - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = StRead;
          col_d   = col_q + 1'b1;
          row_d   = '0;
          cnt_d   = '0;
          entry_d = '0;
          rd_en_d = 1'b1;
          addr_d  = WADDR_WIDTH'(col_d) * WADDR_WIDTH'(SIZE);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      entry_q <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      cw_q    <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      cw_q    <= cw_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wmem_rd_en             = rd_en_q;
  assign wmem_addr              = addr_q;
  assign Compensation_Weight    = cw_q;
  assign Compensation_out_valid = valid_q;
  assign change_col             = chg_q;
  assign load_mem_done          = done_q;
  assign busy                   = busy_q;
  assign overflow               = ovf_q;

endmodule

// File: tb/tb_compensation_weight_generator.sv
// Scoreboard bench: a reference model turns the buffer contents into the expected
// stream of codes and column markers; a negedge monitor consumes DUT output.
module tb_compensation_weight_generator;
  localparam int SIZE = 8;
  localparam int AW   = $clog2(SIZE * SIZE);
  localparam int CHG  = 8;  // queue marker for a change_col pulse

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          wmem_rd_en;
  logic [AW-1:0] wmem_addr;
  logic [7:0]    wmem_data = 8'd0;
  logic [2:0]    Compensation_Weight;
  logic          Compensation_out_valid;
  logic          change_col;
  logic          load_mem_done;
  logic          busy;
  logic          overflow;

  compensation_weight_generator #(.SIZE(SIZE)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .wmem_rd_en             (wmem_rd_en),
    .wmem_addr              (wmem_addr),
    .wmem_data              (wmem_data),
    .Compensation_Weight    (Compensation_Weight),
    .Compensation_out_valid (Compensation_out_valid),
    .change_col             (change_col),
    .load_mem_done          (load_mem_done),
    .busy                   (busy),
    .overflow               (overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [SIZE*SIZE];
  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0;
  int exp_q[$];
  int exp_lat = 0, exp_ovf = 0, exp_addr = 0;
  int vcount = 0, chg_seen = 0;
  logic done_prev = 1'b0;

  // Synchronous weight buffer, one-cycle read latency.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (wmem_rd_en) wmem_data <= mem[wmem_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: codes of the first three outliers per column in row order.
  task automatic build_expected();
    exp_q.delete();
    exp_lat = 0;
    exp_ovf = 0;
    for (int c = 0; c < SIZE; c++) begin
      int n = 0;
      for (int r = 0; r < SIZE; r++) begin
        logic [7:0] w = mem[c*SIZE + r];
        int hi = int'(w) / 32;
        int sx = (int'(w) / 16) % 2 == 1 ? 7 : 0;
        if (hi != sx) begin
          if (n < 3) begin exp_q.push_back(hi); n++; end
          else exp_ovf = 1;
        end
      end
      if (n == 0) begin exp_q.push_back(0); n = 1; end
      exp_q.push_back(CHG);
      exp_lat += SIZE + 1 + n + 1;
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      int e;
      if (Compensation_out_valid && change_col) check("valid_chg_exclusive", 1, 0);
      if (Compensation_out_valid) begin
        vcount++;
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin e = exp_q.pop_front(); check("code", int'(Compensation_Weight), e); end
      end
      if (change_col) begin
        check("valids_per_col_1to3", int'(vcount >= 1 && vcount <= 3), 1);
        vcount = 0;
        chg_seen++;
        if (exp_q.size() == 0) check("unexpected_chg", 1, 0);
        else begin e = exp_q.pop_front(); check("chg_position", CHG, e); end
      end
      if (wmem_rd_en) begin
        check("rd_addr_seq", int'(wmem_addr), exp_addr);
        exp_addr++;
      end
      if (load_mem_done && !done_prev) begin
        check("chg_count", chg_seen, SIZE);
        check("queue_drained", exp_q.size(), 0);
        check("overflow_at_done", int'(overflow), exp_ovf);
        check("done_latency", cyc - t0, exp_lat);
        check("busy_at_done", int'(busy), 0);
      end
    end
    done_prev = load_mem_done;
  end

  task automatic start_scan(input bit mid_start);
    build_expected();
    exp_addr = 0;
    vcount   = 0;
    chg_seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    check("done_low_after_start", int'(load_mem_done), 0);
    check("busy_after_start", int'(busy), 1);
    check("ovf_clear_after_start", int'(overflow), 0);
    check("first_addr", int'(wmem_addr), 0);
    @(negedge clk);
    start = 1'b0;
    if (mid_start) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 2000 && !load_mem_done; i++) @(negedge clk);
    check("done_timeout", int'(load_mem_done), 1);
    repeat (3) @(negedge clk);
    check("done_held", int'(load_mem_done), 1);
    check("no_valid_in_done", int'(Compensation_out_valid), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, int'(wmem_rd_en), 0);
    check({tag, "_addr"}, int'(wmem_addr), 0);
    check({tag, "_code"}, int'(Compensation_Weight), 0);
    check({tag, "_valid"}, int'(Compensation_out_valid), 0);
    check({tag, "_chg"}, int'(change_col), 0);
    check({tag, "_done"}, int'(load_mem_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < SIZE*SIZE; i++) begin
      logic [4:0] x = 5'($urandom);
      if ($urandom_range(0, 5) == 0) mem[i] = 8'($urandom);
      else mem[i] = {{3{x[4]}}, x};
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < SIZE*SIZE; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // All-zero buffer.
    start_scan(1'b0);
    wait_done();

    // Column 0 with two outliers.
    mem[2] = 8'h40;
    mem[5] = 8'hA0;
    start_scan(1'b0);
    wait_done();

    // Column 3 overflow; -11 in column 6 is not an outlier.
    for (int i = 0; i < SIZE*SIZE; i++) mem[i] = 8'd0;
    for (int r = 0; r < 5; r++) mem[3*SIZE + r] = 8'h40;
    mem[6*SIZE + 1] = 8'hF5;
    start_scan(1'b0);
    wait_done();
    check("ovf_sticky_done", int'(overflow), 1);

    // Restart from DONE clears overflow; extra start mid-READ is ignored.
    for (int i = 0; i < SIZE*SIZE; i++) mem[i] = 8'd0;
    start_scan(1'b1);
    wait_done();

    // Random buffers.
    for (int n = 0; n < 6; n++) begin
      fill_random();
      start_scan(1'b0);
      wait_done();
    end

    // Reset during EMIT of column 4.
    fill_random();
    start_scan(1'b0);
    begin
      int i;
      for (i = 0; i < 2000; i++) begin
        @(posedge clk);
        #1;
        if (Compensation_out_valid && chg_seen == 4) break;
      end
      check("reached_col4_emit", int'(Compensation_out_valid && chg_seen == 4), 1);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
    start_scan(1'b0);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
